msg_rx_decoder: RTL and testbench

//  Parametrised UART message decoder for the bot's command link. Sits behind the

---
 rtl/msg_rx_decoder_if.sv | 28 ++
 rtl/msg_rx_decoder.sv | 155 +++++++++++++++
 tb/tb_msg_rx_decoder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/msg_rx_decoder_if.sv
// Byte/strobe input and decoded-flag output bundle of the UART command decoder.
interface msg_rx_decoder_if #(
    parameter int LOC_W = 2
) ();
    logic [7:0]       rx_msg;
    logic             rx_complete;
    logic             flag_clear;
    logic             EU_fault_flag;
    logic             CU_fault_flag;
    logic             RU_fault_flag;
    logic             switch_key;
    logic             pick_block_flag;
    logic [LOC_W-1:0] block_location;
    logic             msg_valid;
    logic             msg_error;

    modport master (
        output rx_msg, rx_complete, flag_clear,
        input  EU_fault_flag, CU_fault_flag, RU_fault_flag, switch_key,
               pick_block_flag, block_location, msg_valid, msg_error
    );

    modport slave (
        input  rx_msg, rx_complete, flag_clear,
        output EU_fault_flag, CU_fault_flag, RU_fault_flag, switch_key,
               pick_block_flag, block_location, msg_valid, msg_error
    );
endinterface

// File: rtl/msg_rx_decoder.sv
// Collects UART bytes into a bounded buffer up to the terminator, then decodes
// IFM fault and PBM pick-block frames into sticky flags with valid/error pulses.
//
// state   | meaning
// IDLE    | waiting for the first byte of a frame
// COLLECT | storing bytes until terminator or buffer full
// DISCARD | frame overflowed; skipping bytes until terminator
// DECODE  | one cycle: match buffer, update flags, pulse valid/error
// CLEAR   | one cycle: zero buffer and index
module msg_rx_decoder #(
    parameter int         MAX_LEN = 12,
    parameter logic [7:0] TERM    = 8'h23,
    parameter int         NUM_LOC = 4,
    parameter int         LOC_W   = 2
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    msg_rx_decoder_if.slave  bus
);
    localparam int               IDX_W    = $clog2(MAX_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LEN - 1);
    localparam logic [7:0]       SEP      = 8'h2D;
    localparam logic [7:0]       DIG_MAX  = 8'(8'h30 + NUM_LOC);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DISCARD, S_DECODE, S_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [7:0]         buf_q [MAX_LEN];
    logic [7:0]         buf_d [MAX_LEN];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               eu_q, eu_d, cu_q, cu_d, ru_q, ru_d, sk_q, sk_d, pick_q, pick_d;
    logic [LOC_W-1:0]   loc_q, loc_d;
    logic               valid_q, valid_d, error_q, error_d, drop_q, drop_d;

    logic               tail_ifm, tail_pbm, is_ifm, is_pbm;
    logic               ifm_e, ifm_c, ifm_r, frame_ok, dec;
    logic [7:0]         loc_full;

    // Bytes past the frame's own length must still be zero from CLEAR.
    always_comb begin
        tail_ifm = 1'b1;
        tail_pbm = 1'b1;
        for (int i = 8; i < MAX_LEN; i++)
            if (buf_q[i] != 8'h00) tail_ifm = 1'b0;
        for (int i = 11; i < MAX_LEN; i++)
            if (buf_q[i] != 8'h00) tail_pbm = 1'b0;
    end

    always_comb begin
        is_ifm = (buf_q[0] == "I") && (buf_q[1] == "F") && (buf_q[2] == "M") &&
                 (buf_q[3] == SEP) && (buf_q[5] == "U") && (buf_q[6] == SEP) &&
                 (buf_q[7] == TERM) && tail_ifm;
        ifm_e  = is_ifm && (buf_q[4] == "E");
        ifm_c  = is_ifm && (buf_q[4] == "C");
        ifm_r  = is_ifm && (buf_q[4] == "R");
        is_pbm = (buf_q[0] == "P") && (buf_q[1] == "B") && (buf_q[2] == "M") &&
                 (buf_q[3] == SEP) && (buf_q[4] == "S") && (buf_q[5] == "U") &&
                 (buf_q[6] == SEP) && (buf_q[7] == "B") &&
                 (buf_q[8] >= 8'h31) && (buf_q[8] <= DIG_MAX) &&
                 (buf_q[9] == SEP) && (buf_q[10] == TERM) && tail_pbm;
        frame_ok = ifm_e || ifm_c || ifm_r || is_pbm;
        loc_full = buf_q[8] - 8'h31;
        dec      = (state_q == S_DECODE);
    end

    // A set in the same cycle as flag_clear wins over the clear.
    always_comb begin
        eu_d   = (dec && ifm_e) || (eu_q && !bus.flag_clear);
        cu_d   = (dec && ifm_c) || (cu_q && !bus.flag_clear);
        ru_d   = (dec && ifm_r) || (ru_q && !bus.flag_clear);
        sk_d   = (dec && (ifm_e || ifm_c || ifm_r)) || (sk_q && !bus.flag_clear);
        pick_d = (dec && is_pbm) || (pick_q && !bus.flag_clear);
        loc_d  = loc_q;
        if (dec && is_pbm)        loc_d = loc_full[LOC_W-1:0];
        else if (bus.flag_clear)  loc_d = '0;
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        drop_d  = 1'b0;
        valid_d = 1'b0;
        error_d = drop_q;
        case (state_q)
            S_IDLE: if (bus.rx_complete) begin
                buf_d[0] = bus.rx_msg;
                idx_d    = IDX_W'(1);
                state_d  = (bus.rx_msg == TERM) ? S_DECODE : S_COLLECT;
            end
            S_COLLECT: if (bus.rx_complete) begin
                buf_d[idx_q] = bus.rx_msg;
                idx_d        = idx_q + IDX_W'(1);
                if (bus.rx_msg == TERM)   state_d = S_DECODE;
                else if (idx_q == LAST_IDX) state_d = S_DISCARD;
            end
            S_DISCARD: if (bus.rx_complete && (bus.rx_msg == TERM)) begin
                error_d = 1'b1;
                state_d = S_CLEAR;
            end
            S_DECODE: begin
                valid_d = frame_ok;
                error_d = !frame_ok;
                drop_d  = bus.rx_complete;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                for (int i = 0; i < MAX_LEN; i++) buf_d[i] = 8'h00;
                idx_d   = '0;
                drop_d  = bus.rx_complete;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 8'h00;
            idx_q   <= '0;
            eu_q    <= 1'b0;
            cu_q    <= 1'b0;
            ru_q    <= 1'b0;
            sk_q    <= 1'b0;
            pick_q  <= 1'b0;
            loc_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            eu_q    <= eu_d;
            cu_q    <= cu_d;
            ru_q    <= ru_d;
            sk_q    <= sk_d;
            pick_q  <= pick_d;
            loc_q   <= loc_d;
            valid_q <= valid_d;
            error_q <= error_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.EU_fault_flag   = eu_q;
    assign bus.CU_fault_flag   = cu_q;
    assign bus.RU_fault_flag   = ru_q;
    assign bus.switch_key      = sk_q;
    assign bus.pick_block_flag = pick_q;
    assign bus.block_location  = loc_q;
    assign bus.msg_valid       = valid_q;
    assign bus.msg_error       = error_q;
endmodule

// File: tb/tb_msg_rx_decoder.sv
// Directed bench for msg_rx_decoder: expected pulses and flag snapshots are
// queued as frames are sent and checked when the decoder pulses.
module tb_msg_rx_decoder;
    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50M = ~clk_50M;

    msg_rx_decoder_if #(.LOC_W(2)) bus ();

    msg_rx_decoder #(.MAX_LEN(12), .TERM(8'h23), .NUM_LOC(4), .LOC_W(2)) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    // flags packed as {EU, CU, RU, switch_key, pick_block, location[1:0]}
    typedef struct {
        logic       valid;
        logic [6:0] flags;
        bit         adj;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_pulse_cyc = -10;

    always @(posedge clk_50M) cyc <= cyc + 1;

    function automatic logic [6:0] obs_flags();
        return {bus.EU_fault_flag, bus.CU_fault_flag, bus.RU_fault_flag,
                bus.switch_key, bus.pick_block_flag, bus.block_location};
    endfunction

    always @(negedge clk_50M) begin
        if (bus.msg_valid || bus.msg_error) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_pulse observed valid=%0b error=%0b expected no pulse",
                       bus.msg_valid, bus.msg_error);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                vectors++;
                assert ({bus.msg_valid, bus.msg_error} === {mon_e.valid, ~mon_e.valid}) else begin
                    miscompares++;
                    $error("FAIL pulse_kind observed v/e=%0b%0b expected %0b%0b",
                           bus.msg_valid, bus.msg_error, mon_e.valid, ~mon_e.valid);
                end
                vectors++;
                assert (obs_flags() === mon_e.flags) else begin
                    miscompares++;
                    $error("FAIL flags_at_pulse observed=%b expected=%b", obs_flags(), mon_e.flags);
                end
                if (mon_e.adj) begin
                    vectors++;
                    assert (cyc === last_pulse_cyc + 1) else begin
                        miscompares++;
                        $error("FAIL drop_timing observed cycle=%0d expected=%0d",
                               cyc, last_pulse_cyc + 1);
                    end
                end
            end
            last_pulse_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [6:0] f, input bit adj);
        sb.push_back('{valid: v, flags: f, adj: adj});
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_msg      = b;
        bus.rx_complete = 1'b1;
        @(posedge clk_50M);
        #1;
        bus.rx_complete = 1'b0;
        repeat (gap) @(posedge clk_50M);
        if (gap > 0) #1;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    initial begin
        bus.rx_msg      = 8'h00;
        bus.rx_complete = 1'b0;
        bus.flag_clear  = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        rst_n = 1'b1;
        chk("reset_flags", 32'(obs_flags()), 32'h0);
        chk("reset_pulses", {30'd0, bus.msg_valid, bus.msg_error}, 32'h0);

        // IFM-EU with UART-rate gaps; flags appear one edge after the DECODE edge
        push(1'b1, 7'b1001000, 1'b0);
        send_str("IFM-EU-", 434);
        send_byte("#", 0);
        chk("t1_before_decode", 32'(bus.EU_fault_flag), 32'h0);
        @(posedge clk_50M); #1;
        chk("t1_eu_flag", 32'(bus.EU_fault_flag), 32'h1);
        chk("t1_valid_pulse", 32'(bus.msg_valid), 32'h1);
        chk("t1_cu_ru", {30'd0, bus.CU_fault_flag, bus.RU_fault_flag}, 32'h0);
        repeat (434) @(posedge clk_50M); #1;

        // flag_clear in the RU decode cycle: RU set wins, EU cleared
        push(1'b1, 7'b0011000, 1'b0);
        send_str("IFM-RU-", 3);
        send_byte("#", 0);
        bus.flag_clear = 1'b1;
        @(posedge clk_50M); #1;
        bus.flag_clear = 1'b0;
        chk("t4_ru_sk_eu", {29'd0, bus.RU_fault_flag, bus.switch_key, bus.EU_fault_flag}, 32'h6);
        repeat (3) @(posedge clk_50M); #1;

        // PBM: in-range digits, out-of-range digits, malformed frames
        push(1'b1, 7'b0011110, 1'b0);
        send_str("PBM-SU-B3-#", 3);
        chk("t2_location", 32'(bus.block_location), 32'h2);
        push(1'b0, 7'b0011110, 1'b0);
        send_str("PBM-SU-B5-#", 3);
        push(1'b1, 7'b0011111, 1'b0);
        send_str("PBM-SU-B4-#", 3);
        push(1'b0, 7'b0011111, 1'b0);
        send_str("PBM-SU-B0-#", 3);
        push(1'b0, 7'b0011111, 1'b0);
        send_str("IFM-XU-#", 3);
        push(1'b0, 7'b0011111, 1'b0);
        send_str("IFM_EU-#", 3);
        push(1'b0, 7'b0011111, 1'b0);
        send_str("IFM-EU-X#", 3);
        push(1'b0, 7'b0011111, 1'b0);
        send_str("#", 3);

        bus.flag_clear = 1'b1;
        @(posedge clk_50M); #1;
        bus.flag_clear = 1'b0;
        chk("clear_all", 32'(obs_flags()), 32'h0);

        // overflow: 15 'A' then '#' -> one error; then recovery
        push(1'b0, 7'b0000000, 1'b0);
        send_str("AAAAAAAAAAAAAAA#", 3);
        push(1'b1, 7'b0101000, 1'b0);
        send_str("IFM-CU-#", 3);
        chk("t3_cu_flag", 32'(bus.CU_fault_flag), 32'h1);

        // reset mid-frame drops it silently
        send_str("PBM-S", 3);
        rst_n = 1'b0;
        @(posedge clk_50M); #1;
        rst_n = 1'b1;
        chk("t5_reset_flags", 32'(obs_flags()), 32'h0);
        chk("t5_reset_pulses", {30'd0, bus.msg_valid, bus.msg_error}, 32'h0);
        push(1'b1, 7'b1001000, 1'b0);
        send_str("IFM-EU-#", 3);

        // byte strobed in the DECODE cycle is dropped, error follows valid
        push(1'b1, 7'b1001000, 1'b0);
        push(1'b0, 7'b1001000, 1'b1);
        send_str("IFM-EU-", 3);
        send_byte("#", 0);
        send_byte("Z", 3);
        push(1'b1, 7'b1011000, 1'b0);
        send_str("IFM-RU-#", 3);

        repeat (10) @(posedge clk_50M); #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
